// File: rtl/seg_pkg.sv
// seg_pkg: shared constants, output bundle and nibble helper
// for the seven-segment scan driver.
package seg_pkg;

   localparam int SEL_W   = 3;
   localparam int NIB_W   = 4;
   localparam int MAX_DIG = 8;

   // Registered output bundle of the scan driver.
   typedef struct packed {
      logic [SEL_W-1:0] sel;
      logic [NIB_W-1:0] hex;
      logic             blank;
      logic             frame_done;
      logic             load_ack;
   } seg_out_t;

   // Nibble idx of a display word (digit k = bits 4k+3:4k).
   function automatic logic [NIB_W-1:0] nib_of(
      input logic [NIB_W*MAX_DIG-1:0] word,
      input logic [SEL_W-1:0]         idx
   );
      return word[{idx, 2'b00} +: NIB_W];
   endfunction

endpackage

// File: rtl/seg_tick_gen.sv
// seg_tick_gen: digit-slot prescaler counting 0..DIV-1 with hold.
// o_in_dead flags the tick about to be entered so a registered blank lines up.
module seg_tick_gen #(
   parameter int DIV  = 100000,
   parameter int DEAD = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_hold,
   output logic o_slot_end,
   output logic o_in_dead
);

   localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [TW-1:0] LAST  = TW'(DIV - 1);
   localparam logic [TW-1:0] DEADV = TW'(DEAD);

   logic [TW-1:0] r_tick;
   logic [TW-1:0] w_tick_nxt;

   // Next tick: wrap at end of slot, freeze while held.
   always_comb begin
      w_tick_nxt = r_tick;
      if (!i_hold) begin
         w_tick_nxt = (r_tick == LAST) ? '0 : r_tick + 1'b1;
      end
   end

   assign o_slot_end = (r_tick == LAST);
   assign o_in_dead  = (w_tick_nxt < DEADV);

   // Slot tick counter.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tick <= '0;
      end else begin
         r_tick <= w_tick_nxt;
      end
   end

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 8-digit seven-segment scan controller.
// Shadowed word/mask swap only on frame wrap; dead-time blank per slot.
module seg_scan_driver
   import seg_pkg::*;
#(
   parameter int DIV  = 100000,
   parameter int DEAD = 4,
   parameter int NDIG = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NIB_W*MAX_DIG-1:0] data_in,
   input  logic [MAX_DIG-1:0]       mask_in,
   input  logic                     load,
   output logic [SEL_W-1:0]         sel,
   output logic [NIB_W-1:0]         hex,
   output logic                     blank,
   output logic                     frame_done,
   output logic                     load_ack
);

   localparam logic [SEL_W-1:0] LAST = SEL_W'(NDIG - 1);

   logic                     w_hold;
   logic                     w_slot_end;
   logic                     w_dead_nxt;
   logic                     w_wrap;
   logic                     w_cap;
   logic [SEL_W-1:0]         w_sel_nxt;
   logic [NIB_W*MAX_DIG-1:0] w_data_nxt;
   logic [MAX_DIG-1:0]       w_mask_nxt;

   logic [NIB_W*MAX_DIG-1:0] r_shadow_data;
   logic [MAX_DIG-1:0]       r_shadow_mask;
   logic                     r_load_pend;
   seg_out_t                 r_out;

   assign w_hold = ~en;

   seg_tick_gen #(
      .DIV  (DIV),
      .DEAD (DEAD)
   ) u_tick (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_hold     (w_hold),
      .o_slot_end (w_slot_end),
      .o_in_dead  (w_dead_nxt)
   );

   assign w_wrap = en & w_slot_end & (r_out.sel == LAST);
   assign w_cap  = w_wrap & (r_load_pend | load);

   // A load on the wrap edge is visible from digit 0 of the new frame.
   assign w_data_nxt = w_cap ? data_in : r_shadow_data;
   assign w_mask_nxt = w_cap ? mask_in : r_shadow_mask;

   // Digit index advances at slot end, wrapping after NDIG-1.
   always_comb begin
      w_sel_nxt = r_out.sel;
      if (en && w_slot_end) begin
         w_sel_nxt = (r_out.sel == LAST) ? '0 : r_out.sel + 1'b1;
      end
   end

   // Shadow registers and merged pending-load flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_shadow_data <= '0;
         r_shadow_mask <= '0;
         r_load_pend   <= 1'b0;
      end else if (w_cap) begin
         r_shadow_data <= data_in;
         r_shadow_mask <= mask_in;
         r_load_pend   <= 1'b0;
      end else if (load) begin
         r_load_pend   <= 1'b1;
      end
   end

   // Registered outputs; hex and blank track the incoming sel.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out.sel        <= '0;
         r_out.hex        <= '0;
         r_out.blank      <= 1'b1;
         r_out.frame_done <= 1'b0;
         r_out.load_ack   <= 1'b0;
      end else begin
         r_out.sel        <= w_sel_nxt;
         r_out.hex        <= nib_of(w_data_nxt, w_sel_nxt);
         r_out.blank      <= ~en | w_dead_nxt | ~w_mask_nxt[w_sel_nxt];
         r_out.frame_done <= w_wrap;
         r_out.load_ack   <= w_cap;
      end
   end

   assign sel        = r_out.sel;
   assign hex        = r_out.hex;
   assign blank      = r_out.blank;
   assign frame_done = r_out.frame_done;
   assign load_ack   = r_out.load_ack;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard plus table-driven checks of the
// scan driver (DIV=4, DEAD=1, NDIG=8) and an NDIG=5 instance.
module tb_seg_scan_driver;

   typedef struct packed {
      logic [2:0] sel;
      logic [3:0] hex;
      logic       blank;
      logic       fd;
      logic       ack;
   } exp_t;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  mask;
      logic [31:0] exp_hex;
      logic [7:0]  exp_vis;
   } vec_t;

   localparam logic [9:0] RST_V = 10'b000_0000_1_0_0;

   logic        clk = 1'b0;
   logic        rst, en, load;
   logic [31:0] data_in;
   logic [7:0]  mask_in;
   logic [2:0]  sel, sel5;
   logic [3:0]  hex, hex5;
   logic        blank, frame_done, load_ack;
   logic        blank5, frame_done5, load_ack5;

   int checks = 0;
   int errors = 0;
   int ack_cnt = 0, fd_cnt = 0, both_cnt = 0;

   int          m_tick, m_sel;
   logic [31:0] m_sd;
   logic [7:0]  m_sm;
   logic        m_pend;
   exp_t        sb_q[$];
   vec_t        tbl[3];

   always #5 clk = ~clk;

   seg_scan_driver #(.DIV(4), .DEAD(1), .NDIG(8)) dut (
      .clk(clk), .rst(rst), .en(en), .data_in(data_in),
      .mask_in(mask_in), .load(load), .sel(sel), .hex(hex),
      .blank(blank), .frame_done(frame_done), .load_ack(load_ack)
   );

   seg_scan_driver #(.DIV(4), .DEAD(1), .NDIG(5)) dut5 (
      .clk(clk), .rst(rst), .en(en), .data_in(data_in),
      .mask_in(mask_in), .load(load), .sel(sel5), .hex(hex5),
      .blank(blank5), .frame_done(frame_done5), .load_ack(load_ack5)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   function automatic exp_t act_out();
      return {sel, hex, blank, frame_done, load_ack};
   endfunction

   task automatic model_reset();
      m_tick = 0; m_sel = 0; m_sd = '0; m_sm = '0; m_pend = 1'b0;
   endtask

   // Reference model of one clock edge from the current inputs.
   task automatic predict();
      exp_t e;
      logic wrap, cap;
      int tn, sn;
      logic [31:0] sd;
      logic [7:0] sm;
      wrap = en && (m_tick == 3) && (m_sel == 7);
      cap  = wrap && (m_pend || load);
      tn = m_tick; sn = m_sel;
      if (en) begin
         if (m_tick == 3) begin
            tn = 0;
            sn = (m_sel == 7) ? 0 : m_sel + 1;
         end else begin
            tn = m_tick + 1;
         end
      end
      sd = cap ? data_in : m_sd;
      sm = cap ? mask_in : m_sm;
      m_pend = cap ? 1'b0 : (load ? 1'b1 : m_pend);
      m_tick = tn; m_sel = sn; m_sd = sd; m_sm = sm;
      e.sel   = 3'(sn);
      e.hex   = sd[4*sn +: 4];
      e.blank = !en || (tn < 1) || !sm[sn];
      e.fd    = wrap;
      e.ack   = cap;
      sb_q.push_back(e);
   endtask

   task automatic step();
      exp_t e, a;
      predict();
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      a = act_out();
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL scoreboard t=%0t: got sel=%0d hex=%h blank=%b fd=%b ack=%b want sel=%0d hex=%h blank=%b fd=%b ack=%b",
                  $time, a.sel, a.hex, a.blank, a.fd, a.ack,
                  e.sel, e.hex, e.blank, e.fd, e.ack);
      end
      if (load_ack) ack_cnt++;
      if (frame_done) fd_cnt++;
      if (load_ack && frame_done) both_cnt++;
   endtask

   // Assert reset in the middle of a cycle; outputs must clear at once.
   task automatic reset_mid();
      #2;
      rst = 1'b1;
      #1;
      chk("rst_async", 32'(act_out()), 32'(RST_V));
      chk("rst_async5", 32'({sel5, hex5, blank5, frame_done5, load_ack5}),
          32'(RST_V));
      @(posedge clk);
      #1;
      chk("rst_hold", 32'(act_out()), 32'(RST_V));
      rst = 1'b0;
      model_reset();
      sb_q.delete();
   endtask

   initial begin
      int n, a0, f0, b0, cnt, nfd;
      logic got;
      logic [2:0] prev, sel_e;
      logic [31:0] old_w, hw;
      logic [7:0] vm;

      tbl[0] = '{32'h76543210, 8'hFF, 32'h76543210, 8'hFF};
      tbl[1] = '{32'h76543210, 8'h0F, 32'h76543210, 8'h0F};
      tbl[2] = '{32'hA5C31E9B, 8'hA6, 32'hA5C31E9B, 8'hA6};

      rst = 1'b1; en = 1'b0; load = 1'b0;
      data_in = '0; mask_in = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("reset_vals", 32'(act_out()), 32'(RST_V));
      chk("reset_vals5", 32'({sel5, hex5, blank5, frame_done5, load_ack5}),
          32'(RST_V));
      rst = 1'b0;
      en  = 1'b1;

      step();
      chk("first_blank", 32'(blank), 32'd1);
      repeat (3) step();
      chk("sel_step1", 32'(sel), 32'd1);
      repeat (4) step();
      chk("sel_step2", 32'(sel), 32'd2);

      // Table: load a word/mask, then check the whole following frame.
      for (int i = 0; i < 3; i++) begin
         data_in = tbl[i].data;
         mask_in = tbl[i].mask;
         load = 1'b1;
         step();
         load = 1'b0;
         got = load_ack;
         n = 0;
         while (!got && n < 100) begin
            step();
            got = load_ack;
            n++;
         end
         chk($sformatf("tbl%0d_ack", i), 32'(got), 32'd1);
         data_in = $urandom;
         mask_in = 8'($urandom);
         hw = tbl[i].exp_hex;
         vm = tbl[i].exp_vis;
         for (int c = 0; c < 32; c++) begin
            if (c > 0) step();
            chk($sformatf("tbl%0d_hex_c%0d", i, c), 32'(hex),
                32'(hw[4*(c/4) +: 4]));
            chk($sformatf("tbl%0d_blank_c%0d", i, c), 32'(blank),
                32'(((c % 4) == 0) || !vm[c/4]));
         end
      end

      // Tear-free load in the middle of a frame.
      old_w = tbl[2].data;
      n = 0;
      while (!(m_sel == 3 && m_tick == 1) && n < 100) begin
         step();
         n++;
      end
      data_in = 32'hFFFFFFFF;
      mask_in = 8'hFF;
      a0 = ack_cnt; f0 = fd_cnt; b0 = both_cnt;
      load = 1'b1;
      n = 0;
      do begin
         step();
         load = 1'b0;
         n++;
         if (!(m_sel == 0 && m_tick == 0))
            chk("tear_old_hex", 32'(hex), 32'(old_w[4*m_sel +: 4]));
      end while (!(m_sel == 0 && m_tick == 0) && n < 100);
      chk("tear_ack_cnt", 32'(ack_cnt - a0), 32'd1);
      chk("tear_fd_cnt", 32'(fd_cnt - f0), 32'd1);
      chk("tear_same_cycle", 32'(both_cnt - b0), 32'd1);
      chk("tear_hex_d0", 32'(hex), 32'hF);
      for (int c = 1; c < 32; c++) begin
         step();
         chk("tear_new_hex", 32'(hex), 32'hF);
         chk("tear_new_blank", 32'(blank), 32'(m_tick == 0));
      end
      chk("tear_ack_once", 32'(ack_cnt - a0), 32'd1);

      // Load pulse on the wrap edge itself.
      n = 0;
      while (!(m_sel == 7 && m_tick == 3) && n < 100) begin
         step();
         n++;
      end
      data_in = 32'h13572468;
      mask_in = 8'hFF;
      load = 1'b1;
      step();
      load = 1'b0;
      chk("wrap_load_ack", 32'(load_ack), 32'd1);
      chk("wrap_load_sel", 32'(sel), 32'd0);
      chk("wrap_load_hex", 32'(hex), 32'h8);
      data_in = $urandom;
      mask_in = 8'($urandom);

      // Enable low for 10 clocks mid-slot, load pulse while stalled.
      step();
      sel_e = 3'(m_sel);
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         load = (i == 4);
         step();
         chk("en_low_freeze",
             32'({sel, blank, frame_done, load_ack}),
             32'({sel_e, 1'b1, 1'b0, 1'b0}));
      end
      load = 1'b0;
      en = 1'b1;
      n = 0;
      do begin
         step();
         n++;
      end while (sel == sel_e && n < 20);
      chk("en_resume_cycles", 32'(n), 32'd3);
      repeat (40) step();

      // Reset in the middle of a slot with a load pending.
      n = 0;
      while (m_tick != 2 && n < 10) begin
         step();
         n++;
      end
      load = 1'b1;
      step();
      load = 1'b0;
      reset_mid();
      a0 = ack_cnt;
      repeat (40) step();
      chk("rst_drops_pending", 32'(ack_cnt - a0), 32'd0);

      // NDIG=5 instance: sel 0..4 and frame_done every 20 clocks.
      reset_mid();
      cnt = 0; nfd = 0; prev = 3'd0;
      for (int i = 0; i < 60; i++) begin
         step();
         cnt++;
         chk("nd5_sel_range", 32'(sel5 <= 3'd4), 32'd1);
         if (sel5 != prev) begin
            chk("nd5_seq", 32'(sel5), 32'((prev == 3'd4) ? 3'd0 : prev + 3'd1));
            prev = sel5;
         end
         if (frame_done5) begin
            chk("nd5_period", 32'(cnt), 32'd20);
            chk("nd5_fd_sel", 32'(sel5), 32'd0);
            cnt = 0;
            nfd++;
         end
      end
      chk("nd5_fd_count", 32'(nfd), 32'd3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
